// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift pipeline: widths, op encodings and bit reversal.
// Rotate support in the top level is enabled by defining ALU_SHIFT_ROTATE_EN.
package alu_shift_pkg;

   localparam int XLEN    = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_ROL = 2'b10,
      OP_SRA = 2'b11
   } shift_op_e;

   function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] d);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = d[XLEN-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/barrel_shl_32b.sv
// 32-bit logarithmic left barrel shifter: one conditional power-of-two stage per shamt bit.
module barrel_shl_32b
   import alu_shift_pkg::*;
(
   input  logic [XLEN-1:0]    data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [XLEN-1:0]    data_o
);

   // Cascade of shift-by-2^i stages.
   always_comb begin
      logic [XLEN-1:0] v;
      v = data_i;
      for (int i = 0; i < SHAMT_W; i++) begin
         v = shamt_i[i] ? (v << (32'd1 << i)) : v;
      end
      data_o = v;
   end

endmodule

// File: rtl/bit_reverse_32b.sv
// Combinational 32-bit bit reversal, used around the left shifter to form right shifts.
module bit_reverse_32b
   import alu_shift_pkg::*;
(
   input  logic [XLEN-1:0] d_i,
   output logic [XLEN-1:0] q_o
);

   assign q_o = rev(d_i);

endmodule

// File: rtl/alu_shift_pipe.sv
// Two-stage SLL/SRL/SRA shift unit with valid/ready handshake on both sides.
// Define ALU_SHIFT_ROTATE_EN to make op 2'b10 a rotate-left; otherwise it passes the operand through.
module alu_shift_pipe
   import alu_shift_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [XLEN-1:0]    in_a,
   input  logic [SHAMT_W-1:0] in_shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_result
);

   logic               s1_valid_q, s1_valid_d;
   shift_op_e          s1_op_q, s1_op_d;
   logic [XLEN-1:0]    s1_a_q, s1_a_d;
   logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
   logic               out_valid_q, out_valid_d;
   logic [XLEN-1:0]    out_result_q, out_result_d;

   logic               adv_s, accept_s, load_s2_s;
   logic [XLEN-1:0]    pre_rev_s, pre_s, sh_s, post_rev_s, post_s, sra_mask_s, result_s;

   assign adv_s     = !out_valid_q || out_ready;
   assign in_ready  = !rst && (!s1_valid_q || adv_s);
   assign accept_s  = in_valid && in_ready;
   assign load_s2_s = s1_valid_q && adv_s;

   // Right shifts run through the left shifter on the reversed operand.
   bit_reverse_32b u_rev_pre (.d_i(s1_a_q), .q_o(pre_rev_s));
   assign pre_s = s1_op_q[0] ? pre_rev_s : s1_a_q;

   barrel_shl_32b u_shl (.data_i(pre_s), .shamt_i(s1_shamt_q), .data_o(sh_s));

   bit_reverse_32b u_rev_post (.d_i(sh_s), .q_o(post_rev_s));
   assign post_s = s1_op_q[0] ? post_rev_s : sh_s;

   assign sra_mask_s = ~rev({XLEN{1'b1}} << s1_shamt_q);

`ifdef ALU_SHIFT_ROTATE_EN
   logic [SHAMT_W-1:0] rot_amt_s;
   logic [XLEN-1:0]    rot_sh_s;

   // a >> (32-s) == rev(rev(a) << (32-s)); 32-s wraps to 0 when s=0, giving a|a = a.
   assign rot_amt_s = {SHAMT_W{1'b0}} - s1_shamt_q;
   barrel_shl_32b u_shl_rot (.data_i(pre_rev_s), .shamt_i(rot_amt_s), .data_o(rot_sh_s));
`endif

   // Final result select per op.
   always_comb begin
      result_s = post_s;
      case (s1_op_q)
         OP_SLL:  result_s = post_s;
         OP_SRL:  result_s = post_s;
         OP_SRA:  result_s = post_s | (s1_a_q[XLEN-1] ? sra_mask_s : {XLEN{1'b0}});
`ifdef ALU_SHIFT_ROTATE_EN
         OP_ROL:  result_s = sh_s | rev(rot_sh_s);
`else
         OP_ROL:  result_s = s1_a_q;
`endif
         default: result_s = post_s;
      endcase
   end

   // Next-state for both pipeline stages.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_op_d      = s1_op_q;
      s1_a_d       = s1_a_q;
      s1_shamt_d   = s1_shamt_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;

      if (accept_s) begin
         s1_valid_d = 1'b1;
         s1_op_d    = shift_op_e'(in_op);
         s1_a_d     = in_a;
         s1_shamt_d = in_shamt;
      end else if (load_s2_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (load_s2_s) begin
         out_valid_d  = 1'b1;
         out_result_d = result_s;
      end else if (out_ready) begin
         out_valid_d  = 1'b0;
      end else begin
         out_valid_d  = out_valid_q;
      end
   end

   // Stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= OP_SLL;
         s1_a_q       <= {XLEN{1'b0}};
         s1_shamt_q   <= {SHAMT_W{1'b0}};
         out_valid_q  <= 1'b0;
         out_result_q <= {XLEN{1'b0}};
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_op_q      <= s1_op_d;
         s1_a_q       <= s1_a_d;
         s1_shamt_q   <= s1_shamt_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;

endmodule
